// File: rtl/conv_pkg.sv
// Types and constants shared by the row loader and the convolution layer.
package conv_pkg;

    localparam int unsigned IMG_ROWS = 6;
    localparam int unsigned IMG_COLS = 6;

    typedef logic [IMG_ROWS*IMG_COLS-1:0] frame_t;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        SEND
    } load_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser + optional debouncer + registered rising-edge pulse for one async level.
// Debouncer included when MATRIX_ROW_LOADER_DEBOUNCE_EN is defined.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   level_q;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("sync_edge_detect: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

`ifdef MATRIX_ROW_LOADER_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // Counter runs only while the raw level disagrees with the debounced one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= sync_q[SYNC_STAGES-1];
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_comb level = db_level;
`else
    always_comb level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/matrix_row_loader.sv
// Captures a ROWS x COLS binary image row by row from switches and hands it downstream via valid/ready.
// Optional input debouncing: define MATRIX_ROW_LOADER_DEBOUNCE_EN.
module matrix_row_loader
    import conv_pkg::*;
#(
    parameter int unsigned ROWS            = IMG_ROWS,
    parameter int unsigned COLS            = IMG_COLS,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COLS-1:0]            row_bits,
    input  logic                       row_strobe,
    input  logic                       load_req,
    input  logic                       err_clr,
    output logic [ROWS*COLS-1:0]       frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [$clog2(ROWS+1)-1:0]  row_count,
    output logic                       overflow,
    output logic                       underrun
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] ALL_ROWS = CNT_W'(ROWS);

    load_state_t     state;
    load_state_t     state_next;
    logic            strobe_pulse;
    logic            load_pulse;
    logic            ovf_set;
    logic            unr_set;
    logic [COLS-1:0] rows_q   [ROWS];
    // One stage longer than the synchroniser so data lines up with the registered strobe pulse.
    logic [COLS-1:0] bits_pipe[SYNC_STAGES+1];

    sync_edge_detect #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strobe_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(row_strobe),
        .pulse   (strobe_pulse)
    );

    sync_edge_detect #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(load_req),
        .pulse   (load_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= SYNC_STAGES; i++) bits_pipe[i] <= '0;
        end else begin
            bits_pipe[0] <= row_bits;
            for (int unsigned i = 1; i <= SYNC_STAGES; i++) bits_pipe[i] <= bits_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FILL:    if (strobe_pulse && row_count >= LAST_ROW) state_next = FULL;
            FULL:    if (load_pulse) state_next = SEND;
            SEND:    if (frame_valid && frame_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        frame_valid = (state == SEND);
        ovf_set     = strobe_pulse && (state != FILL);
        unr_set     = load_pulse && (state == FILL);
    end

    // Error set takes priority over a coincident err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overflow <= ovf_set | (overflow & ~err_clr);
            underrun <= unr_set | (underrun & ~err_clr);
            if (state == FILL && strobe_pulse && row_count < ALL_ROWS) begin
                rows_q[row_count] <= bits_pipe[SYNC_STAGES];
                row_count         <= row_count + 1'b1;
            end else if (state == SEND && frame_valid && frame_ready) begin
                for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
                row_count <= '0;
            end
        end
    end

    always_comb begin
        frame_data = '0;
        for (int unsigned r = 0; r < ROWS; r++) frame_data[r*COLS +: COLS] = rows_q[r];
    end

endmodule

// File: tb/tb_matrix_row_loader.sv
// Directed self-checking bench for matrix_row_loader: vector table plus multi-cycle corner sequences.
module tb_matrix_row_loader;
    import conv_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 8;
`ifdef MATRIX_ROW_LOADER_DEBOUNCE_EN
    localparam int unsigned DB_ADD = DB;
`else
    localparam int unsigned DB_ADD = 0;
`endif
    // Edges from an input rise (just after an edge) to the visible output update.
    localparam int unsigned LAT  = SYNC + 2 + DB_ADD;
    localparam int unsigned HOLD = LAT + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  row_bits = '0;
    logic        row_strobe = 1'b0;
    logic        load_req = 1'b0;
    logic        err_clr = 1'b0;
    logic [35:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [2:0]  row_count;
    logic        overflow;
    logic        underrun;

    matrix_row_loader #(
        .ROWS           (6),
        .COLS           (6),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_bits   (row_bits),
        .row_strobe (row_strobe),
        .load_req   (load_req),
        .err_clr    (err_clr),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .row_count  (row_count),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum {OP_ROW, OP_LOAD, OP_CLR, OP_ACCEPT} op_e;
    typedef struct {
        op_e         op;
        logic [5:0]  bits;
        logic [2:0]  cnt;
        logic        valid;
        logic        under;
        logic        over;
        logic [35:0] frame;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_row(input logic [5:0] bits);
        row_bits   = bits;
        row_strobe = 1'b1;
        tick(HOLD);
        row_strobe = 1'b0;
        tick(HOLD);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(HOLD);
        load_req = 1'b0;
        tick(HOLD);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        tick(2);
        frame_ready = 1'b0;
        tick(1);
    endtask

    task automatic check_all(input string tag, input logic [2:0] cnt, input logic valid,
                             input logic under, input logic over, input logic [35:0] frame);
        check({tag, " row_count"}, row_count, cnt);
        check({tag, " frame_valid"}, frame_valid, valid);
        check({tag, " underrun"}, underrun, under);
        check({tag, " overflow"}, overflow, over);
        check({tag, " frame_data"}, frame_data, frame);
    endtask

    initial begin : main
        logic [35:0] exp_frame;
        int unsigned n;

        vecs[0]  = '{OP_ROW,    6'h01, 3'd1, 1'b0, 1'b0, 1'b0, 36'h000000001};
        vecs[1]  = '{OP_ROW,    6'h02, 3'd2, 1'b0, 1'b0, 1'b0, 36'h000000081};
        vecs[2]  = '{OP_ROW,    6'h04, 3'd3, 1'b0, 1'b0, 1'b0, 36'h000004081};
        vecs[3]  = '{OP_LOAD,   6'h00, 3'd3, 1'b0, 1'b1, 1'b0, 36'h000004081};
        vecs[4]  = '{OP_CLR,    6'h00, 3'd3, 1'b0, 1'b0, 1'b0, 36'h000004081};
        vecs[5]  = '{OP_ROW,    6'h08, 3'd4, 1'b0, 1'b0, 1'b0, 36'h000204081};
        vecs[6]  = '{OP_ROW,    6'h10, 3'd5, 1'b0, 1'b0, 1'b0, 36'h010204081};
        vecs[7]  = '{OP_ROW,    6'h20, 3'd6, 1'b0, 1'b0, 1'b0, 36'h810204081};
        vecs[8]  = '{OP_ROW,    6'h3F, 3'd6, 1'b0, 1'b0, 1'b1, 36'h810204081};
        vecs[9]  = '{OP_CLR,    6'h00, 3'd6, 1'b0, 1'b0, 1'b0, 36'h810204081};
        vecs[10] = '{OP_LOAD,   6'h00, 3'd6, 1'b1, 1'b0, 1'b0, 36'h810204081};
        vecs[11] = '{OP_ROW,    6'h15, 3'd6, 1'b1, 1'b0, 1'b1, 36'h810204081};
        vecs[12] = '{OP_ACCEPT, 6'h00, 3'd0, 1'b0, 1'b0, 1'b1, 36'h000000000};
        vecs[13] = '{OP_CLR,    6'h00, 3'd0, 1'b0, 1'b0, 1'b0, 36'h000000000};

        tick(3);
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 36'h0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) begin
            unique case (vecs[i].op)
                OP_ROW:    drive_row(vecs[i].bits);
                OP_LOAD:   pulse_load();
                OP_CLR:    clear_err();
                OP_ACCEPT: accept();
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].valid,
                      vecs[i].under, vecs[i].over, vecs[i].frame);
        end

        // Strobe-to-row_count latency, counted in clock edges.
        row_bits   = 6'h2A;
        row_strobe = 1'b1;
        n = 0;
        for (int unsigned e = 1; e <= LAT + 4; e++) begin
            tick(1);
            if (row_count != 3'd0) begin
                n = e;
                break;
            end
        end
        check("strobe latency", 64'(n), 64'(LAT));
        row_strobe = 1'b0;
        tick(HOLD);
        check("latency row data", frame_data, 36'h00000002A);

        // Strobe and load_req together at row_count = 5.
        drive_row(6'h11);
        drive_row(6'h22);
        drive_row(6'h33);
        drive_row(6'h0C);
        row_bits   = 6'h3F;
        row_strobe = 1'b1;
        load_req   = 1'b1;
        tick(HOLD);
        row_strobe = 1'b0;
        load_req   = 1'b0;
        tick(HOLD);
        exp_frame = {6'h3F, 6'h0C, 6'h33, 6'h22, 6'h11, 6'h2A};
        check_all("simul", 3'd6, 1'b0, 1'b1, 1'b0, exp_frame);
        clear_err();
        check("simul err_clr underrun", underrun, 1'b0);

        // load_req to frame_valid latency, then hold with ready low.
        load_req = 1'b1;
        n = 0;
        for (int unsigned e = 1; e <= LAT + 4; e++) begin
            tick(1);
            if (frame_valid) begin
                n = e;
                break;
            end
        end
        check("valid latency", 64'(n), 64'(LAT));
        load_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("hold%0d frame_valid", c), frame_valid, 1'b1);
            check($sformatf("hold%0d frame_data", c), frame_data, exp_frame);
        end
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        check_all("accept", 3'd0, 1'b0, 1'b0, 1'b0, 36'h0);

        // Ready already high before valid: transfer completes by itself.
        frame_ready = 1'b1;
        drive_row(6'h01);
        drive_row(6'h03);
        drive_row(6'h07);
        drive_row(6'h0F);
        drive_row(6'h1F);
        drive_row(6'h3F);
        check("early ready row_count", row_count, 3'd6);
        check("early ready no valid", frame_valid, 1'b0);
        pulse_load();
        check_all("early ready", 3'd0, 1'b0, 1'b0, 1'b0, 36'h0);
        frame_ready = 1'b0;

        // Asynchronous reset while in SEND with overflow set.
        drive_row(6'h05);
        drive_row(6'h05);
        drive_row(6'h05);
        drive_row(6'h05);
        drive_row(6'h05);
        drive_row(6'h05);
        pulse_load();
        drive_row(6'h09);
        check("pre-reset valid", frame_valid, 1'b1);
        check("pre-reset overflow", overflow, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async reset", 3'd0, 1'b0, 1'b0, 1'b0, 36'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        drive_row(6'h2D);
        check_all("after reset", 3'd1, 1'b0, 1'b0, 1'b0, 36'h00000002D);

`ifdef MATRIX_ROW_LOADER_DEBOUNCE_EN
        row_bits   = 6'h3C;
        row_strobe = 1'b1;
        tick(3);
        row_strobe = 1'b0;
        tick(HOLD + DB);
        check("glitch row_count", row_count, 3'd1);
        check("glitch frame_data", frame_data, 36'h00000002D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
